// File: rtl/ibex_iter_clmul.sv
// Iterative carry-less multiply / CRC32(C) unit; StepBits operand bits per BUSY cycle, result after max(1, N/StepBits) edges.
// Backpressure: result held in DONE until ready_i; optional CRC datapath guarded by IBEX_ITER_CLMUL_CRC_EN.
module ibex_iter_clmul #(
    parameter int unsigned Width    = 32,
    parameter int unsigned StepBits = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);
    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic                 unsup_q;
    logic [CntW-1:0]      cnt_q, limit_q;
    logic [2*Width-1:0]   a_q, a_d, acc_q, acc_d;
    logic [Width-1:0]     b_q, b_d;
    logic [Width-1:0]     result_q, res_d;
    logic                 accept, last_step;

    logic                 req_unsup;
    int unsigned          req_nbits;
    logic [CntW-1:0]      req_limit;

`ifdef IBEX_ITER_CLMUL_CRC_EN
    localparam logic CrcEn = 1'b1;
    logic                 cz_q;
    logic [6:0]           nbits_q;
    logic [Width-1:0]     crc_q, crc_d, poly;
`else
    localparam logic CrcEn = 1'b0;
    logic                 unused_op_bit;
    assign unused_op_bit = op_i[3];
`endif

    assign accept    = valid_i && ready_o && !kill_i;
    assign last_step = (cnt_q == limit_q - CntW'(1));

    // Request decode: bit count N and the resulting BUSY cycle count.
    always_comb begin
        req_unsup = 1'b0;
        req_nbits = Width;
        case (op_i[2:0])
            3'd0, 3'd1, 3'd2: req_nbits = Width;
            3'd3:             req_unsup = 1'b1;
            3'd4:             begin req_nbits = 8;  req_unsup = !CrcEn; end
            3'd5:             begin req_nbits = 16; req_unsup = !CrcEn; end
            3'd6:             begin req_nbits = 32; req_unsup = !CrcEn; end
            default:          begin req_nbits = 64; req_unsup = !CrcEn || (Width == 32); end
        endcase
        if (req_unsup) begin
            req_limit = CntW'(1);
        end else begin
            req_limit = CntW'((req_nbits + StepBits - 1) / StepBits);
        end
    end

    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < int'(StepBits); j++) begin
            if (b_q[j]) acc_d = acc_d ^ (a_q << j);
        end
        a_d = a_q << StepBits;
        b_d = b_q >> StepBits;
    end

`ifdef IBEX_ITER_CLMUL_CRC_EN
    assign poly = cz_q ? Width'(32'h82F63B78) : Width'(32'hEDB88320);

    // Short CRC ops with large StepBits must stop after exactly N shifts.
    always_comb begin
        crc_d = crc_q;
        for (int j = 0; j < int'(StepBits); j++) begin
            if (j < int'(nbits_q)) crc_d = (crc_d >> 1) ^ (crc_d[0] ? poly : '0);
        end
    end
`endif

    always_comb begin
        res_d = '0;
        if (!unsup_q) begin
            case (op_q)
                3'd0:    res_d = acc_d[Width-1:0];
                3'd1:    res_d = acc_d[2*Width-1:Width];
                3'd2:    res_d = acc_d[2*Width-2:Width-1];
`ifdef IBEX_ITER_CLMUL_CRC_EN
                default: res_d = crc_d;
`else
                default: res_d = '0;
`endif
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: begin
                if (kill_i)         state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE: if (kill_i || ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            unsup_q  <= 1'b0;
            cnt_q    <= '0;
            limit_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_i[2:0];
                unsup_q <= req_unsup;
                cnt_q   <= '0;
                limit_q <= req_limit;
                a_q     <= {{Width{1'b0}}, operand_a_i};
                b_q     <= operand_b_i;
                acc_q   <= '0;
            end else if (state_q == BUSY && !kill_i) begin
                cnt_q <= cnt_q + CntW'(1);
                a_q   <= a_d;
                b_q   <= b_d;
                acc_q <= acc_d;
                if (last_step) result_q <= res_d;
            end
        end
    end

`ifdef IBEX_ITER_CLMUL_CRC_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cz_q    <= 1'b0;
            nbits_q <= '0;
            crc_q   <= '0;
        end else if (accept) begin
            cz_q    <= op_i[3];
            nbits_q <= 7'(req_nbits);
            crc_q   <= operand_a_i;
        end else if (state_q == BUSY && !kill_i) begin
            crc_q <= crc_d;
        end
    end
`endif

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule
